// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction controller.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] DUMMY_BYTE = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun
  } xfer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and count; head is raw memory, caller masks on empty.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [Width-1:0] din_i,
  input  logic             rd_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountFull = Depth[PtrW:0];

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [Width-1:0] mem_q [Depth];
  logic push, pop;

  assign full_o  = (count_q == CountFull);
  assign empty_o = (count_q == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push    = wr_i && !full_o;
  assign pop     = rd_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Host-side SPI burst controller: feeds spi_master from a TX FIFO and collects replies in an RX FIFO.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_wr,
  input  logic [BYTE_W-1:0] tx_din,
  output logic              tx_full,
  input  logic              rx_rd,
  output logic [BYTE_W-1:0] rx_dout,
  output logic              rx_empty,
  input  logic              go,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              tx_underrun,
  output logic              rx_overrun,
  input  logic              clr_err,
  output logic [BYTE_W-1:0] thr,
  output logic              start_tick,
  output logic              last_xfer,
  input  logic              txrdy_tick,
  input  logic              rxrdy_tick,
  input  logic              done_tick,
  input  logic [BYTE_W-1:0] rhr
);

  xfer_state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, sent_q, sent_d;
  logic done_q, done_d;
  logic tx_underrun_q, tx_underrun_d, rx_overrun_q, rx_overrun_d;
  logic in_run, tx_pop, rx_push, tx_empty, rx_full;
  logic [BYTE_W-1:0] tx_head, rx_head;

  // Master ticks only matter while a burst is running.
  assign in_run  = (state_q == StRun);
  assign tx_pop  = in_run && txrdy_tick;
  assign rx_push = in_run && rxrdy_tick;

  sync_fifo #(
    .Width(BYTE_W),
    .Depth(DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (tx_wr),
    .din_i  (tx_din),
    .rd_i   (tx_pop),
    .dout_o (tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty)
  );

  sync_fifo #(
    .Width(BYTE_W),
    .Depth(DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_i   (rx_push),
    .din_i  (rhr),
    .rd_i   (rx_rd),
    .dout_o (rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty)
  );

  assign thr        = tx_empty ? DUMMY_BYTE : tx_head;
  assign rx_dout    = rx_empty ? DUMMY_BYTE : rx_head;
  assign busy       = (state_q != StIdle);
  assign start_tick = (state_q == StLaunch);
  assign last_xfer  = in_run && (sent_q == len_q);
  assign done       = done_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_overrun  = rx_overrun_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sent_d  = sent_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (go && (len != '0)) begin
          state_d = StLaunch;
          len_d   = len;
          sent_d  = '0;
        end
      end
      StLaunch: state_d = StRun;
      StRun: begin
        if (txrdy_tick) begin
          sent_d = sent_q + 1'b1;
        end
        if (done_tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_underrun_d = tx_underrun_q | (tx_pop && tx_empty);
    rx_overrun_d  = rx_overrun_q | (rx_push && rx_full);
    if (clr_err) begin
      tx_underrun_d = 1'b0;
      rx_overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      sent_q        <= '0;
      done_q        <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sent_q        <= sent_d;
      done_q        <= done_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: master model plus a queue-based reference model.
module tb_spi_xfer_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam logic [23:0] RESET_VEC = 24'h04_00_00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_wr = 1'b0, rx_rd = 1'b0, go = 1'b0, clr_err = 1'b0;
  logic txrdy_tick = 1'b0, rxrdy_tick = 1'b0, done_tick = 1'b0;
  logic [7:0] tx_din = 8'h00, rhr = 8'h00;
  logic [LEN_W-1:0] len = '0;
  logic tx_full, rx_empty, busy, done, tx_underrun, rx_overrun, start_tick, last_xfer;
  logic [7:0] rx_dout, thr;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 launch, 2 run.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] src_rx[$];
  int m_state, m_len, m_sent;
  bit m_done, m_txu, m_rxo;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_wr      (tx_wr),
    .tx_din     (tx_din),
    .tx_full    (tx_full),
    .rx_rd      (rx_rd),
    .rx_dout    (rx_dout),
    .rx_empty   (rx_empty),
    .go         (go),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .tx_underrun(tx_underrun),
    .rx_overrun (rx_overrun),
    .clr_err    (clr_err),
    .thr        (thr),
    .start_tick (start_tick),
    .last_xfer  (last_xfer),
    .txrdy_tick (txrdy_tick),
    .rxrdy_tick (rxrdy_tick),
    .done_tick  (done_tick),
    .rhr        (rhr)
  );

  function automatic logic [23:0] obs_vec();
    return {busy, done, start_tick, last_xfer, tx_full, rx_empty, tx_underrun, rx_overrun,
            thr, rx_dout};
  endfunction

  function automatic logic [23:0] exp_vec();
    logic [7:0] et, er;
    et = (m_tx.size() > 0) ? m_tx[0] : 8'h00;
    er = (m_rx.size() > 0) ? m_rx[0] : 8'h00;
    return {m_state != 0, m_done, m_state == 1, (m_state == 2) && (m_sent == m_len),
            m_tx.size() == DEPTH, m_rx.size() == 0, m_txu, m_rxo, et, er};
  endfunction

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_state = 0;
    m_len   = 0;
    m_sent  = 0;
    m_done  = 0;
    m_txu   = 0;
    m_rxo   = 0;
  endtask

  task automatic idle_inputs();
    tx_wr = 0; rx_rd = 0; go = 0; clr_err = 0;
    txrdy_tick = 0; rxrdy_tick = 0; done_tick = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit run, tx_push, rx_pop, rx_push;
    run     = (m_state == 2);
    tx_push = tx_wr && (m_tx.size() < DEPTH);
    rx_pop  = rx_rd && (m_rx.size() > 0);
    rx_push = run && rxrdy_tick && (m_rx.size() < DEPTH);
    if (run && txrdy_tick) begin
      if (m_tx.size() > 0) void'(m_tx.pop_front());
      else m_txu = 1;
      m_sent++;
    end
    if (tx_push) m_tx.push_back(tx_din);
    if (run && rxrdy_tick && m_rx.size() == DEPTH) m_rxo = 1;
    if (rx_pop) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(rhr);
    if (clr_err) begin
      m_txu = 0;
      m_rxo = 0;
    end
    m_done = 0;
    case (m_state)
      0: if (go && len != 0) begin
        m_state = 1;
        m_len   = int'(len);
        m_sent  = 0;
      end
      1: m_state = 2;
      default: if (done_tick) begin
        m_state = 0;
        m_done  = 1;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    idle_inputs();
    tx_wr  = 1;
    tx_din = b;
    tick();
    tx_wr = 0;
  endtask

  task automatic start(input int n);
    idle_inputs();
    go  = 1;
    len = LEN_W'(n);
    tick();
    go = 0;
    tick();
  endtask

  // Master model: n loads and captures at random spacing, then done_tick; checks every cycle.
  task automatic master_burst(input string tag, input int n, input bit rnd);
    int plan[$];
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) plan.push_back(0);
      plan.push_back(1);
      repeat ($urandom_range(0, 2)) plan.push_back(0);
      plan.push_back(2);
    end
    plan.push_back(3);
    plan.push_back(0);
    for (int k = 0; k < plan.size(); k++) begin
      idle_inputs();
      rhr = 8'($urandom);
      case (plan[k])
        1: txrdy_tick = 1;
        2: begin
          rxrdy_tick = 1;
          if (src_rx.size() > 0) rhr = src_rx.pop_front();
        end
        3: done_tick = 1;
        default: ;
      endcase
      if (rnd) begin
        tx_wr   = ($urandom_range(0, 2) == 0);
        tx_din  = 8'($urandom);
        rx_rd   = ($urandom_range(0, 3) == 0);
        clr_err = ($urandom_range(0, 9) == 0);
        if (k < plan.size() - 1) begin
          go  = ($urandom_range(0, 4) == 0);
          len = LEN_W'($urandom);
        end
      end
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", obs_vec(), RESET_VEC);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_rx[3];
    exp_rx = '{8'h11, 8'h22, 8'h33};
    push_tx(8'hA5);
    push_tx(8'h3C);
    push_tx(8'hF0);
    checks++;
    if (thr !== 8'hA5) begin
      failures++;
      $display("FAIL basic_thr_head: got %h expected a5", thr);
    end
    idle_inputs();
    go  = 1;
    len = 3;
    tick();
    go = 0;
    checks++;
    if ({start_tick, busy} !== 2'b11) begin
      failures++;
      $display("FAIL basic_launch: got start=%b busy=%b expected 1 1", start_tick, busy);
    end
    tick();
    checks++;
    if ({start_tick, busy, last_xfer} !== 3'b010) begin
      failures++;
      $display("FAIL basic_run: got start=%b busy=%b last=%b expected 0 1 0",
               start_tick, busy, last_xfer);
    end
    src_rx = '{8'h11, 8'h22, 8'h33};
    master_burst("basic", 3, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_dout !== exp_rx[i]) begin
        failures++;
        $display("FAIL basic_rx[%0d]: got %h expected %h", i, rx_dout, exp_rx[i]);
      end
      rx_rd = 1;
      tick();
      rx_rd = 0;
    end
    checks++;
    if ({rx_empty, tx_underrun, rx_overrun} !== 3'b100) begin
      failures++;
      $display("FAIL basic_end: got empty=%b txu=%b rxo=%b expected 1 0 0",
               rx_empty, tx_underrun, rx_overrun);
    end
  endtask

  task automatic test_underrun();
    push_tx(8'($urandom));
    start(2);
    master_burst("underrun", 2, 0);
    checks++;
    if ({tx_underrun, busy} !== 2'b10) begin
      failures++;
      $display("FAIL underrun_flag: got txu=%b busy=%b expected 1 0", tx_underrun, busy);
    end
    clr_err = 1;
    rx_rd   = 1;
    tick();
    rx_rd = 1;
    clr_err = 0;
    tick();
    rx_rd = 0;
    checks++;
    if ({tx_underrun, rx_empty} !== 2'b01) begin
      failures++;
      $display("FAIL underrun_clear: got txu=%b empty=%b expected 0 1", tx_underrun, rx_empty);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < DEPTH; i++) push_tx(8'(i + 8'h40));
    for (int i = 0; i < 10; i++) src_rx.push_back(8'(8'h80 + i));
    start(10);
    master_burst("overrun", 10, 0);
    checks++;
    if ({rx_overrun, rx_dout} !== {1'b1, 8'h80}) begin
      failures++;
      $display("FAIL overrun_flag: got rxo=%b head=%h expected 1 80", rx_overrun, rx_dout);
    end
    // clr_err in the same cycle as a fresh underrun and overrun must win.
    start(1);
    txrdy_tick = 1;
    rxrdy_tick = 1;
    clr_err    = 1;
    tick();
    idle_inputs();
    checks++;
    if ({tx_underrun, rx_overrun} !== 2'b00) begin
      failures++;
      $display("FAIL clr_priority: got txu=%b rxo=%b expected 0 0", tx_underrun, rx_overrun);
    end
    done_tick = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rx_dout !== 8'(8'h80 + i)) begin
        failures++;
        $display("FAIL overrun_rx[%0d]: got %h expected %h", i, rx_dout, 8'(8'h80 + i));
      end
      rx_rd = 1;
      tick();
      rx_rd = 0;
    end
  endtask

  task automatic test_ignored();
    push_tx(8'h5A);
    push_tx(8'hC3);
    idle_inputs();
    go  = 1;
    len = 2;
    tick();
    len = 5;
    tick();
    checks++;
    if ({start_tick, busy} !== 2'b01) begin
      failures++;
      $display("FAIL go_in_launch: got start=%b busy=%b expected 0 1", start_tick, busy);
    end
    tick();
    go = 0;
    checks++;
    if ({start_tick, busy, last_xfer} !== 3'b010) begin
      failures++;
      $display("FAIL go_in_run: got start=%b busy=%b last=%b expected 0 1 0",
               start_tick, busy, last_xfer);
    end
    master_burst("ignored", 2, 0);
    go  = 1;
    len = 0;
    tick();
    go = 0;
    checks++;
    if ({start_tick, busy} !== 2'b00) begin
      failures++;
      $display("FAIL go_len0: got start=%b busy=%b expected 0 0", start_tick, busy);
    end
    // Master ticks outside a burst must not pop, push or pulse done.
    push_tx(8'h77);
    txrdy_tick = 1;
    rxrdy_tick = 1;
    done_tick  = 1;
    rhr        = 8'hEE;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL idle_ticks: got %h expected %h", obs_vec(), exp_vec());
    end
    repeat (2) begin
      rx_rd = 1;
      tick();
    end
    rx_rd = 0;
  endtask

  task automatic test_reset_mid();
    push_tx(8'h12);
    push_tx(8'h34);
    start(3);
    txrdy_tick = 1;
    tick();
    idle_inputs();
    rxrdy_tick = 1;
    rhr = 8'h9A;
    tick();
    idle_inputs();
    reset = 1;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid_async: got %h expected %h", obs_vec(), RESET_VEC);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid_edge: got %h expected %h", obs_vec(), RESET_VEC);
    end
    reset = 0;
    tick();
    push_tx(8'hB1);
    push_tx(8'hB2);
    start(2);
    master_burst("after_reset", 2, 0);
    while (m_rx.size() > 0) begin
      rx_rd = 1;
      tick();
    end
    rx_rd = 0;
  endtask

  task automatic test_fifo_boundaries();
    while (m_tx.size() < DEPTH) push_tx(8'($urandom));
    push_tx(8'hEE);
    checks++;
    if ({tx_full, thr} !== {1'b1, m_tx[0]}) begin
      failures++;
      $display("FAIL tx_full_drop: got full=%b thr=%h expected 1 %h", tx_full, thr, m_tx[0]);
    end
    start(DEPTH);
    txrdy_tick = 1;
    tx_wr      = 1;
    tx_din     = 8'h66;
    tick();
    checks++;
    if ({tx_full, thr} !== {1'b0, m_tx[0]}) begin
      failures++;
      $display("FAIL push_pop_full: got full=%b thr=%h expected 0 %h", tx_full, thr, m_tx[0]);
    end
    tx_din = 8'h88;
    tick();
    checks++;
    if (tx_full !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_same_count: got full=%b expected 0", tx_full);
    end
    txrdy_tick = 0;
    tx_din     = 8'h99;
    tick();
    tx_wr = 0;
    checks++;
    if (tx_full !== 1'b1) begin
      failures++;
      $display("FAIL refill_full: got full=%b expected 1", tx_full);
    end
    master_burst("fifo", DEPTH - 2, 0);
    while (m_rx.size() > 0) begin
      rx_rd = 1;
      tick();
    end
    rx_rd = 0;
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 10; b++) begin
      repeat ($urandom_range(0, DEPTH)) push_tx(8'($urandom));
      n = $urandom_range(1, (1 << LEN_W) - 1);
      for (int i = 0; i < n; i++) src_rx.push_back(8'($urandom));
      start(n);
      master_burst("random", n, 1);
      src_rx.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
        checks++;
        if (rx_dout !== ((m_rx.size() > 0) ? m_rx[0] : 8'h00)) begin
          failures++;
          $display("FAIL random_drain b%0d i%0d: got %h", b, i, rx_dout);
        end
        rx_rd = 1;
        tick();
      end
      rx_rd = 0;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_end b%0d: got %h expected %h", b, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_ignored();
    test_reset_mid();
    test_fifo_boundaries();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
